// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I constants and the fetch FSM state type.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {BOOT, RUN, HALTED} fetch_state_e;
endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// fetch_prefetch_unit_if: instruction-memory port, decode handshake and EX/halt control of the fetch unit.
interface fetch_prefetch_unit_if #(parameter int IMEM_AW = 8);
  import riscv_pkg::*;
  logic imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic halt_req;
  logic halted;
  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_instr, halted,
    input imem_rdata, out_ready, redirect_valid, redirect_pc, halt_req
  );
  modport slave (
    input imem_req, imem_addr, out_valid, out_pc, out_instr, halted,
    output imem_rdata, out_ready, redirect_valid, redirect_pc, halt_req
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: FIFO of {pc, instr} pairs with synchronous flush; the head reads as zero while empty.
module fetch_queue
  import riscv_pkg::*;
#(parameter int DEPTH = 4) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [XLEN-1:0] push_pc,
  input  logic [XLEN-1:0] push_instr,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_instr,
  output logic [$clog2(DEPTH):0] count,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [2*XLEN-1:0] mem [DEPTH];
  logic full;
  assign count = wr_ptr - rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign {head_pc, head_instr} = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= {push_pc, push_instr};
  // Issue credit bounds count+inflight by DEPTH, so this can only fire on a credit bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) push |-> !full);
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: owns the PC, reads 1-cycle-latency imem and queues instructions for decode.
// FETCH_PERF_CNT_EN adds saturating stall-cycle and redirect counters.
module fetch_prefetch_unit
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int IMEM_AW = 8
) (
  input logic clk,
  input logic reset,
  fetch_prefetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] perf_stall_cycles,
  output logic [XLEN-1:0] perf_redirects
`endif
);
  fetch_state_e state, state_nxt;
  logic [XLEN-1:0] pc, inflight_pc;
  logic inflight, issue, push, pop, empty;
  logic [$clog2(DEPTH):0] count;
  always_comb begin
    state_nxt = state;
    issue = 1'b0;
    if (bus.redirect_valid) state_nxt = RUN;
    else begin
      issue = state == RUN && (32'(count) + 32'(inflight)) < DEPTH;
      state_nxt = state == BOOT ? RUN : (state == RUN && bus.halt_req) ? HALTED : state;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= BOOT;
      pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
    end else begin
      state <= state_nxt;
      inflight <= issue;
      if (issue) inflight_pc <= pc;
      if (bus.redirect_valid) pc <= bus.redirect_pc & ~32'h3;
      else if (issue) pc <= pc + 32'd4;
    end
  // A redirect discards the response landing this cycle and hides the head from decode.
  assign push = inflight && !bus.redirect_valid;
  assign bus.out_valid = !empty && !bus.redirect_valid;
  assign pop = bus.out_valid && bus.out_ready;
  assign bus.imem_req = issue;
  assign bus.imem_addr = pc[IMEM_AW+1:2];
  assign bus.halted = state == HALTED;
  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .flush(bus.redirect_valid),
    .push_pc(inflight_pc),
    .push_instr(bus.imem_rdata),
    .head_pc(bus.out_pc),
    .head_instr(bus.out_instr),
    .count(count),
    .empty(empty)
  );
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_redirects <= '0;
    end else begin
      if (bus.out_valid && !bus.out_ready && ~&perf_stall_cycles) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (bus.redirect_valid && ~&perf_redirects) perf_redirects <= perf_redirects + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed bench for fetch_prefetch_unit with a 1-cycle-latency imem model.
module tb_fetch_prefetch_unit;
  logic clk = 1'b0;
  logic reset;
  int compared = 0;
  int mismatched = 0;
  logic [31:0] mem [256];
  fetch_prefetch_unit_if #(.IMEM_AW(8)) bus ();
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_redirects;
`endif
  fetch_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0), .IMEM_AW(8)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_redirects(perf_redirects)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.imem_req) bus.imem_rdata <= mem[bus.imem_addr];
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.halt_req = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    mem[0] = 32'h00500093;
    mem[1] = 32'h00a00113;
    mem[2] = 32'h002081b3;
    #3;
    chk("rst_req", 32'(bus.imem_req), 0);
    chk("rst_addr", 32'(bus.imem_addr), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_pc", bus.out_pc, 0);
    chk("rst_instr", bus.out_instr, 0);
    chk("rst_halted", 32'(bus.halted), 0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_stall", perf_stall_cycles, 0);
    chk("rst_perf_redir", perf_redirects, 0);
`endif
    tick;
    tick;
    reset = 1'b0;
    #1;
    chk("c0_boot_req", 32'(bus.imem_req), 0);
    tick; #1;
    chk("c1_req", 32'(bus.imem_req), 1);
    chk("c1_addr", 32'(bus.imem_addr), 0);
    tick; #1;
    chk("c2_valid", 32'(bus.out_valid), 0);
    tick; #1;
    chk("c3_valid", 32'(bus.out_valid), 1);
    chk("c3_pc", bus.out_pc, 32'h0);
    chk("c3_instr", bus.out_instr, 32'h00500093);
    tick; #1;
    chk("c4_pc", bus.out_pc, 32'h4);
    chk("c4_instr", bus.out_instr, 32'h00a00113);
    tick; #1;
    chk("c5_pc", bus.out_pc, 32'h8);
    chk("c5_instr", bus.out_instr, 32'h002081b3);
    tick;
    bus.out_ready = 1'b0;
    #1;
    chk("stall_head", bus.out_pc, 32'hC);
    tick;
    tick;
    tick; #1;
    chk("stall_full_req", 32'(bus.imem_req), 0);
    for (int i = 0; i < 6; i++) tick;
    #1;
    chk("stall_end_valid", 32'(bus.out_valid), 1);
    chk("stall_end_pc", bus.out_pc, 32'hC);
    chk("stall_end_req", 32'(bus.imem_req), 0);
    tick;
    bus.out_ready = 1'b1;
    #1;
    chk("rel0_pc", bus.out_pc, 32'hC);
    chk("rel0_req", 32'(bus.imem_req), 0);
    tick; #1;
    chk("rel1_pc", bus.out_pc, 32'h10);
    chk("rel1_req", 32'(bus.imem_req), 1);
    chk("rel1_addr", 32'(bus.imem_addr), 7);
    tick; #1;
    chk("rel2_pc", bus.out_pc, 32'h14);
    tick; #1;
    chk("rel3_pc", bus.out_pc, 32'h18);
    tick;
    bus.out_ready = 1'b0;
    #1;
    chk("rel4_pc", bus.out_pc, 32'h1C);
    chk("rel4_instr", bus.out_instr, 32'hC0DE0007);
    tick;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    #1;
    chk("redir_valid", 32'(bus.out_valid), 0);
    chk("redir_req", 32'(bus.imem_req), 0);
    tick;
    bus.redirect_valid = 1'b0;
    #1;
    chk("redir1_req", 32'(bus.imem_req), 1);
    chk("redir1_addr", 32'(bus.imem_addr), 32'h10);
    chk("redir1_valid", 32'(bus.out_valid), 0);
    tick; #1;
    chk("redir2_valid", 32'(bus.out_valid), 0);
    tick; #1;
    chk("redir3_valid", 32'(bus.out_valid), 1);
    chk("redir3_pc", bus.out_pc, 32'h40);
    chk("redir3_instr", bus.out_instr, 32'hC0DE0010);
    tick; #1;
    chk("redir4_pc", bus.out_pc, 32'h44);
    tick;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h43;
    bus.halt_req = 1'b1;
    #1;
    chk("rh_valid", 32'(bus.out_valid), 0);
    tick;
    bus.redirect_valid = 1'b0;
    bus.halt_req = 1'b0;
    #1;
    chk("rh_halted", 32'(bus.halted), 0);
    chk("rh_req", 32'(bus.imem_req), 1);
    chk("rh_addr", 32'(bus.imem_addr), 32'h10);
    tick;
    tick; #1;
    chk("rh_pc", bus.out_pc, 32'h40);
    tick;
    bus.halt_req = 1'b1;
    #1;
    chk("halt_req_cycle_req", 32'(bus.imem_req), 1);
    chk("halt_req_cycle_halted", 32'(bus.halted), 0);
    chk("halt_req_cycle_pc", bus.out_pc, 32'h44);
    tick;
    bus.halt_req = 1'b0;
    #1;
    chk("halted_rise", 32'(bus.halted), 1);
    chk("halted_req", 32'(bus.imem_req), 0);
    chk("halted_drain0", bus.out_pc, 32'h48);
    tick; #1;
    chk("halted_drain1", bus.out_pc, 32'h4C);
    chk("halted_req1", 32'(bus.imem_req), 0);
    tick;
    bus.halt_req = 1'b1;
    #1;
    chk("halted_empty", 32'(bus.out_valid), 0);
    chk("halted_still", 32'(bus.halted), 1);
    tick;
    bus.halt_req = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h8;
    #1;
    chk("unhalt_redir_req", 32'(bus.imem_req), 0);
    tick;
    bus.redirect_valid = 1'b0;
    #1;
    chk("unhalt_halted", 32'(bus.halted), 0);
    chk("unhalt_req", 32'(bus.imem_req), 1);
    chk("unhalt_addr", 32'(bus.imem_addr), 2);
    tick;
    tick; #1;
    chk("unhalt_pc", bus.out_pc, 32'h8);
    chk("unhalt_instr", bus.out_instr, 32'h002081b3);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall", perf_stall_cycles, 11);
    chk("perf_redir", perf_redirects, 3);
`endif
    tick;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_req", 32'(bus.imem_req), 0);
    chk("mid_rst_pc", bus.out_pc, 0);
    tick;
    reset = 1'b0;
    #1;
    chk("re_c0_req", 32'(bus.imem_req), 0);
    chk("re_c0_valid", 32'(bus.out_valid), 0);
    tick; #1;
    chk("re_c1_addr", 32'(bus.imem_addr), 0);
    chk("re_c1_req", 32'(bus.imem_req), 1);
    tick; #1;
    chk("re_c2_valid", 32'(bus.out_valid), 0);
    tick; #1;
    chk("re_c3_pc", bus.out_pc, 32'h0);
    chk("re_c3_instr", bus.out_instr, 32'h00500093);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
